// File: rtl/serial_results_requester_pkg.sv
// ---------------------------------------------------------------------------
// serial_results_requester_pkg
//   Shared definitions for the sum/max serial protocol requester: FSM state
//   encoding, protocol constants and a small unsigned max helper.
// ---------------------------------------------------------------------------
package serial_results_requester_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND_HDR  = 3'd1,
        ST_SEND_DATA = 3'd2,
        ST_WAIT_RESP = 3'd3,
        ST_FINISH    = 3'd4
    } state_e;

    // Response frame: ACK, SUM, MAX
    localparam logic [7:0] ACK_BYTE   = 8'h00;
    localparam logic [1:0] RESP_BYTES = 2'd3;

    function automatic logic [7:0] max_u8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_results_requester.sv
// ---------------------------------------------------------------------------
// serial_results_requester
//   Host-side initiator for the sum/max serial protocol. Sends header byte N
//   followed by N payload bytes through a byte-level UART TX, gathers the
//   3-byte response (ACK, SUM, MAX) from a byte-level UART RX, and compares
//   it with the SUM/MAX computed locally over the transmitted payload.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start, n_bytes        transaction request (sampled in IDLE) and length
//   pl_valid, pl_data     payload source; pl_ready pulses when a byte is taken
//   tx_send_trig/_data    UART TX request; tx_bsy is the UART TX busy flag
//   rx_data_valid/rx_data UART RX byte strobe and data
//   busy, done            transaction in progress / 1-cycle completion pulse
//   res_sum, res_max      received SUM and MAX
//   match                 response equals ACK + locally computed SUM/MAX
//   err_len, err_timeout  zero-length request / response timeout
// ---------------------------------------------------------------------------
module serial_results_requester
    import serial_results_requester_pkg::*;
#(
    parameter int RESP_TIMEOUT = 2700,
    parameter int TO_W         = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] n_bytes,
    input  logic       pl_valid,
    input  logic [7:0] pl_data,
    output logic       pl_ready,
    output logic       tx_send_trig,
    output logic [7:0] tx_send_data,
    input  logic       tx_bsy,
    input  logic       rx_data_valid,
    input  logic [7:0] rx_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] res_sum,
    output logic [7:0] res_max,
    output logic       match,
    output logic       err_len,
    output logic       err_timeout
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(RESP_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [7:0]      n_q, n_d;
    logic [7:0]      sent_q, sent_d;
    logic [7:0]      exp_sum_q, exp_sum_d;
    logic [7:0]      exp_max_q, exp_max_d;
    logic [7:0]      ack_q, ack_d;
    logic [7:0]      res_sum_q, res_sum_d;
    logic [7:0]      res_max_q, res_max_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [1:0]      rx_cnt_q, rx_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            tx_wait_q, tx_wait_d;   // trigger issued, waiting for bsy to rise and fall
    logic            tx_rose_q, tx_rose_d;   // bsy has been seen high for the pending byte
    logic            match_q, match_d;
    logic            err_len_q, err_len_d;
    logic            err_to_q, err_to_d;

    logic            trig;
    logic            ready;
    logic [7:0]      tx_byte;
    logic            tx_free;
    logic            tx_idle;
    logic            rx_on;
    logic            rx_take;
    logic            all_rx;

    // A new trigger is allowed only once the previous byte has completed a
    // full bsy rise/fall; the pending flag also rules out back-to-back pulses.
    assign tx_free = !tx_wait_q && !tx_bsy;
    // The last byte is finished as soon as bsy is seen low after its rise,
    // so the response window opens in that same cycle.
    assign tx_idle = tx_wait_q ? (tx_rose_q && !tx_bsy) : !tx_bsy;

    assign rx_on   = (state_q == ST_SEND_HDR) || (state_q == ST_SEND_DATA) ||
                     (state_q == ST_WAIT_RESP);
    assign rx_take = rx_on && rx_data_valid && (rx_cnt_q < RESP_BYTES);

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        sent_d    = sent_q;
        exp_sum_d = exp_sum_q;
        exp_max_d = exp_max_q;
        ack_d     = ack_q;
        res_sum_d = res_sum_q;
        res_max_d = res_max_q;
        tx_data_d = tx_data_q;
        rx_cnt_d  = rx_cnt_q;
        to_cnt_d  = to_cnt_q;
        tx_wait_d = tx_wait_q;
        tx_rose_d = tx_rose_q;
        match_d   = match_q;
        err_len_d = err_len_q;
        err_to_d  = err_to_q;
        trig      = 1'b0;
        ready     = 1'b0;
        tx_byte   = tx_data_q;

        // Response capture runs alongside transmission; extra bytes dropped.
        if (rx_take) begin
            case (rx_cnt_q)
                2'd0:    ack_d     = rx_data;
                2'd1:    res_sum_d = rx_data;
                default: res_max_d = rx_data;
            endcase
            rx_cnt_d = rx_cnt_q + 2'd1;
        end
        all_rx = (rx_cnt_d == RESP_BYTES);

        if (tx_wait_q) begin
            if (tx_bsy) begin
                tx_rose_d = 1'b1;
            end else if (tx_rose_q) begin
                tx_wait_d = 1'b0;
                tx_rose_d = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    match_d   = 1'b0;
                    err_to_d  = 1'b0;
                    res_sum_d = 8'h00;
                    res_max_d = 8'h00;
                    ack_d     = 8'h00;
                    rx_cnt_d  = 2'd0;
                    to_cnt_d  = '0;
                    if (n_bytes == 8'h00) begin
                        err_len_d = 1'b1;
                        state_d   = ST_FINISH;
                    end else begin
                        err_len_d = 1'b0;
                        n_d       = n_bytes;
                        sent_d    = 8'h00;
                        exp_sum_d = 8'h00;
                        exp_max_d = 8'h00;
                        state_d   = ST_SEND_HDR;
                    end
                end
            end

            ST_SEND_HDR: begin
                if (tx_free) begin
                    trig    = 1'b1;
                    tx_byte = n_q;
                    state_d = ST_SEND_DATA;
                end
            end

            ST_SEND_DATA: begin
                if (sent_q != n_q) begin
                    if (tx_free && pl_valid) begin
                        trig      = 1'b1;
                        ready     = 1'b1;
                        tx_byte   = pl_data;
                        sent_d    = sent_q + 8'd1;
                        exp_sum_d = exp_sum_q + pl_data;
                        exp_max_d = max_u8(exp_max_q, pl_data);
                    end
                end else if (tx_idle) begin
                    // This cycle already counts as the first idle cycle.
                    state_d  = ST_WAIT_RESP;
                    to_cnt_d = TO_W'(1);
                end
            end

            ST_WAIT_RESP: begin
                if (all_rx) begin
                    match_d = (ack_d == ACK_BYTE) && (res_sum_d == exp_sum_q) &&
                              (res_max_d == exp_max_q);
                    state_d = ST_FINISH;
                end else if (rx_data_valid) begin
                    // A byte arriving on the terminal count wins.
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    err_to_d = 1'b1;
                    match_d  = 1'b0;
                    state_d  = ST_FINISH;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            ST_FINISH: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (trig) begin
            tx_wait_d = 1'b1;
            tx_rose_d = 1'b0;
            tx_data_d = tx_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            n_q       <= 8'h00;
            sent_q    <= 8'h00;
            exp_sum_q <= 8'h00;
            exp_max_q <= 8'h00;
            ack_q     <= 8'h00;
            res_sum_q <= 8'h00;
            res_max_q <= 8'h00;
            tx_data_q <= 8'h00;
            rx_cnt_q  <= 2'd0;
            to_cnt_q  <= '0;
            tx_wait_q <= 1'b0;
            tx_rose_q <= 1'b0;
            match_q   <= 1'b0;
            err_len_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            sent_q    <= sent_d;
            exp_sum_q <= exp_sum_d;
            exp_max_q <= exp_max_d;
            ack_q     <= ack_d;
            res_sum_q <= res_sum_d;
            res_max_q <= res_max_d;
            tx_data_q <= tx_data_d;
            rx_cnt_q  <= rx_cnt_d;
            to_cnt_q  <= to_cnt_d;
            tx_wait_q <= tx_wait_d;
            tx_rose_q <= tx_rose_d;
            match_q   <= match_d;
            err_len_q <= err_len_d;
            err_to_q  <= err_to_d;
        end
    end

    // The byte being triggered goes out directly; the register then holds it
    // stable for the UART until the next trigger.
    assign tx_send_trig = trig;
    assign tx_send_data = trig ? tx_byte : tx_data_q;
    assign pl_ready     = ready;
    assign busy         = (state_q == ST_SEND_HDR) || (state_q == ST_SEND_DATA) ||
                          (state_q == ST_WAIT_RESP);
    assign done         = (state_q == ST_FINISH);
    assign res_sum      = res_sum_q;
    assign res_max      = res_max_q;
    assign match        = match_q;
    assign err_len      = err_len_q;
    assign err_timeout  = err_to_q;

endmodule

// File: tb/tb_serial_results_requester.sv
// ---------------------------------------------------------------------------
// tb_serial_results_requester
//   Directed bench: a behavioural byte-level UART TX (bsy for a few cycles per
//   byte), a payload queue, and rx bytes driven by each scenario task.
// ---------------------------------------------------------------------------
module tb_serial_results_requester;

    localparam int T       = 2700;
    localparam int TX_BUSY = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] n_bytes;
    logic       pl_valid;
    logic [7:0] pl_data;
    logic       pl_ready;
    logic       tx_send_trig;
    logic [7:0] tx_send_data;
    logic       tx_bsy;
    logic       rx_data_valid;
    logic [7:0] rx_data;
    logic       busy;
    logic       done;
    logic [7:0] res_sum;
    logic [7:0] res_max;
    logic       match;
    logic       err_len;
    logic       err_timeout;

    int checks = 0;
    int errors = 0;

    serial_results_requester #(.RESP_TIMEOUT(T), .TO_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_bytes(n_bytes),
        .pl_valid(pl_valid), .pl_data(pl_data), .pl_ready(pl_ready),
        .tx_send_trig(tx_send_trig), .tx_send_data(tx_send_data), .tx_bsy(tx_bsy),
        .rx_data_valid(rx_data_valid), .rx_data(rx_data),
        .busy(busy), .done(done), .res_sum(res_sum), .res_max(res_max),
        .match(match), .err_len(err_len), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment models
    logic [7:0] pl_q[$];
    logic [7:0] tx_log[$];
    logic       hs_ready = 1'b0;
    logic       hs_trig  = 1'b0;
    logic [7:0] hs_data  = 8'h00;
    int         bsy_cnt  = 0;
    int         fall_cyc = 0;
    int         trig_viol = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;

    // Inputs change on the falling edge; handshakes are sampled 1 time unit
    // later and take effect at the next falling edge.
    always @(negedge clk) begin
        if (hs_ready && pl_q.size() > 0) void'(pl_q.pop_front());
        if (hs_trig) begin
            tx_log.push_back(hs_data);
            tx_bsy  = 1'b1;
            bsy_cnt = TX_BUSY;
        end else if (bsy_cnt > 0) begin
            bsy_cnt--;
            if (bsy_cnt == 0) begin
                tx_bsy   = 1'b0;
                fall_cyc = cyc;
            end
        end
        pl_valid = (pl_q.size() > 0);
        pl_data  = (pl_q.size() > 0) ? pl_q[0] : 8'h00;
        #1;
        if (tx_send_trig && (tx_bsy || hs_trig)) trig_viol++;
        hs_ready = pl_ready;
        hs_trig  = tx_send_trig;
        hs_data  = tx_send_data;
    end

    always @(posedge clk) begin
        #2;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic pulse_start(input logic [7:0] n);
        @(posedge clk); #2;
        start   = 1'b1;
        n_bytes = n;
        @(posedge clk); #2;
        start   = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        @(posedge clk); #2;
        rx_data_valid = 1'b1;
        rx_data       = b;
        @(posedge clk); #2;
        rx_data_valid = 1'b0;
    endtask

    task automatic wait_txlog(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (tx_log.size() >= n && !tx_bsy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int d0, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #3;
            if (done_cnt > d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; n_bytes = 8'h00; tx_bsy = 1'b0;
        rx_data_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({busy, done, pl_ready, tx_send_trig, match, err_len, err_timeout} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {busy, done, pl_ready, tx_send_trig, match, err_len, err_timeout});
        end
        checks++;
        if ({res_sum, res_max, tx_send_data} !== 24'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 000000", {res_sum, res_max, tx_send_data});
        end
        rst_n = 1'b1;
        // rx bytes in IDLE must be ignored
        rx_byte(8'h55);
        repeat (2) @(posedge clk); #2;
        checks++;
        if (res_sum !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_rx_ignored: res_sum %h busy %b expected 00 0", res_sum, busy);
        end
    endtask

    task automatic test_basic;
        int base, d0;
        bit ok;
        base = tx_log.size(); d0 = done_cnt;
        pl_q.push_back(8'h10); pl_q.push_back(8'h20); pl_q.push_back(8'h05);
        pulse_start(8'd3);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
        wait_txlog(base + 2, 200, ok);
        rx_byte(8'h00);   // ACK during payload send
        wait_txlog(base + 4, 300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_tx_wait: got timeout expected 4 bytes sent"); end
        rx_byte(8'h35);
        rx_byte(8'h20);
        wait_done(d0, 100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_done: got no done expected done"); end
        checks++;
        if (tx_log.size() != base + 4 ||
            {tx_log[base], tx_log[base+1], tx_log[base+2], tx_log[base+3]} !== 32'h03102005) begin
            errors++;
            $display("FAIL basic_tx_bytes: got %0d bytes expected 03 10 20 05", tx_log.size() - base);
        end
        checks++;
        if ({res_sum, res_max, match, err_len, err_timeout, busy} !== {8'h35, 8'h20, 4'b1000}) begin
            errors++;
            $display("FAIL basic_result: got %h %h m%b l%b t%b b%b expected 35 20 m1 l0 t0 b0",
                     res_sum, res_max, match, err_len, err_timeout, busy);
        end
    endtask

    task automatic test_wrap;
        int base, d0;
        bit ok;
        base = tx_log.size(); d0 = done_cnt;
        pl_q.push_back(8'hFF); pl_q.push_back(8'h02);
        pulse_start(8'd2);
        wait_txlog(base + 3, 300, ok);
        rx_byte(8'h00); rx_byte(8'h02); rx_byte(8'hFF);
        wait_done(d0, 100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wrap_done: got no done expected done"); end
        checks++;
        if ({res_sum, res_max, match, err_timeout} !== {8'h02, 8'hFF, 2'b00}) begin
            errors++;
            $display("FAIL wrap_result: got %h %h m%b t%b expected 02 ff m0 t0",
                     res_sum, res_max, match, err_timeout);
        end
        checks++;
        if (tx_log.size() != base + 3 || tx_log[base+1] !== 8'hFF || tx_log[base+2] !== 8'h02) begin
            errors++;
            $display("FAIL wrap_tx_bytes: got %0d bytes expected 02 ff 02", tx_log.size() - base);
        end
    endtask

    task automatic test_zero_len;
        int base, d0, c0;
        bit ok;
        base = tx_log.size(); d0 = done_cnt;
        @(posedge clk); #2;
        c0 = cyc;
        start = 1'b1; n_bytes = 8'h00;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(d0, 20, ok);
        checks++;
        if (!ok || done_cyc != c0 + 1) begin
            errors++;
            $display("FAIL zero_done_cycle: got %0d expected %0d", done_cyc, c0 + 1);
        end
        repeat (20) @(posedge clk); #2;
        checks++;
        if ({err_len, match, err_timeout, busy} !== 4'b1000 || tx_log.size() != base) begin
            errors++;
            $display("FAIL zero_result: got l%b m%b t%b b%b tx%0d expected l1 m0 t0 b0 tx0",
                     err_len, match, err_timeout, busy, tx_log.size() - base);
        end
    endtask

    task automatic test_timeout;
        int d0;
        bit ok;
        d0 = done_cnt;
        pl_q.push_back(8'h42);
        pulse_start(8'd1);
        wait_done(d0, T + 300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL timeout_done: got no done expected done"); end
        checks++;
        if (done_cyc - fall_cyc != T) begin
            errors++;
            $display("FAIL timeout_latency: got %0d expected %0d", done_cyc - fall_cyc, T);
        end
        checks++;
        if ({err_timeout, match, err_len} !== 3'b100) begin
            errors++;
            $display("FAIL timeout_flags: got t%b m%b l%b expected t1 m0 l0", err_timeout, match, err_len);
        end
    endtask

    task automatic test_stall;
        int base, d0, n_trig;
        bit ok;
        base = tx_log.size(); d0 = done_cnt;
        pl_q.push_back(8'h11);
        pulse_start(8'd3);
        wait_txlog(base + 2, 200, ok);
        n_trig = tx_log.size();
        rx_byte(8'h00);
        repeat (50) @(posedge clk);
        pulse_start(8'd5);   // ignored: transaction in progress
        repeat (50) @(posedge clk); #2;
        checks++;
        if (tx_log.size() != n_trig || busy !== 1'b1 || done_cnt != d0 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: got tx%0d b%b d%0d t%b expected tx%0d b1 d%0d t0",
                     tx_log.size(), busy, done_cnt, err_timeout, n_trig, d0);
        end
        pl_q.push_back(8'h22); pl_q.push_back(8'h33);
        wait_txlog(base + 4, 300, ok);
        rx_byte(8'h66); rx_byte(8'h33);
        wait_done(d0, 100, ok);
        checks++;
        if (!ok || {res_sum, res_max, match} !== {8'h66, 8'h33, 1'b1}) begin
            errors++;
            $display("FAIL stall_result: got %h %h m%b expected 66 33 m1", res_sum, res_max, match);
        end
        checks++;
        if (tx_log.size() != base + 4 || tx_log[base] !== 8'h03 || tx_log[base+3] !== 8'h33) begin
            errors++;
            $display("FAIL stall_tx_bytes: got %0d bytes expected 03 11 22 33", tx_log.size() - base);
        end
    endtask

    task automatic test_reset_mid;
        int base, d0;
        bit ok;
        pl_q.push_back(8'hA0); pl_q.push_back(8'hB0); pl_q.push_back(8'hC0);
        pulse_start(8'd3);
        wait_txlog(tx_log.size() + 2, 200, ok);
        repeat (2) @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, pl_ready, tx_send_trig, match, err_len, err_timeout} !== 7'b0 ||
            {res_sum, res_max} !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %b %h %h expected all zero",
                     {busy, done, pl_ready, tx_send_trig, match, err_len, err_timeout}, res_sum, res_max);
        end
        pl_q.delete();
        hs_ready = 1'b0; hs_trig = 1'b0; bsy_cnt = 0; tx_bsy = 1'b0;
        repeat (3) @(posedge clk); #2;
        rst_n = 1'b1;
        base = tx_log.size(); d0 = done_cnt;
        pl_q.push_back(8'h7E);
        pulse_start(8'd1);
        wait_txlog(base + 2, 200, ok);
        rx_byte(8'h00); rx_byte(8'h7E); rx_byte(8'h7E);
        wait_done(d0, 100, ok);
        checks++;
        if (!ok || match !== 1'b1 || tx_log.size() != base + 2 ||
            tx_log[base] !== 8'h01 || tx_log[base+1] !== 8'h7E) begin
            errors++;
            $display("FAIL reset_mid_recover: got m%b tx%0d expected m1 tx 01 7e",
                     match, tx_log.size() - base);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_wrap;
        test_zero_len;
        test_timeout;
        test_stall;
        test_reset_mid;
        checks++;
        if (trig_viol != 0) begin
            errors++;
            $display("FAIL tx_trigger_rule: got %0d violations expected 0", trig_viol);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
